gf_serial_host: RTL and testbench
=================================

GF_SERIAL_HOST -- requirements
Module: gf_serial_host

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width DW.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, idle cycles between enable pulse and capture (0 allowed).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_valid in 1 / req_ready out 1  request handshake.
REQ-006 SHALL have ports req_a, req_b  in  DW  operands.
REQ-007 SHALL have port req_grade  in  $clog2(DW)+1  polynomial grade.
REQ-008 SHALL have port req_poly  in  DW+1  reduction polynomial.
REQ-009 SHALL have port req_red  in  2*DW  reduction input.
REQ-010 SHALL have ports req_sum_funct, req_exp_funct, req_red_funct, req_carry_option  in  1 each  function selects.
REQ-011 SHALL have ports ser_a, ser_b, ser_grade, ser_poly, ser_red  out  1 each  serial operand lines to the core shell.
REQ-012 SHALL have ports sum_funct, exp_funct, red_funct, carry_option, enable  out  1 each  core controls.
REQ-013 SHALL have ports ser_out, ser_out_mult  in  1 each  serial result lines from the core shell.
REQ-014 SHALL have ports rsp_valid out 1 / rsp_ready in 1  response handshake.
REQ-015 SHALL have ports rsp_result out DW, rsp_mult out 2*DW, busy out 1 (high whenever state != IDLE).

Function
REQ-016 SHALL implement states IDLE, SHIFT, ENABLE, WAIT, CAPTURE, RESP.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on a cycle with req_valid && req_ready, all req_* fields registered that cycle.
REQ-018 SHALL move IDLE->SHIFT on acceptance; SHIFT lasts exactly 2*DW cycles.
REQ-019 SHALL, in SHIFT cycle k (0..2*DW-1), drive each ser_* line with bit (2*DW-1-k) of its field zero-extended to 2*DW bits (MSB first, short fields lead with zeros, all fields end aligned on the last SHIFT cycle).
REQ-020 SHALL drive all ser_* lines 0 outside SHIFT.
REQ-021 SHALL hold sum_funct/exp_funct/red_funct/carry_option at the registered request values from the cycle after acceptance until return to IDLE; 0 in IDLE.
REQ-022 SHALL spend exactly one cycle in ENABLE with enable=1; enable=0 in every other state.
REQ-023 SHALL spend exactly WAIT_CYCLES cycles in WAIT (skip WAIT when 0), then enter CAPTURE.
REQ-024 SHALL spend exactly 2*DW cycles in CAPTURE, each cycle shifting ser_out_mult into LSB of a 2*DW register and ser_out into LSB of a DW register (first sampled bit ends as MSB); result register keeps the last DW samples.
REQ-025 SHALL enter RESP after CAPTURE, raising rsp_valid with rsp_mult/rsp_result stable until rsp_valid && rsp_ready.
REQ-026 SHALL go RESP->IDLE on handshake; req_ready first asserts the following cycle (no same-cycle turnaround).
REQ-027 SHALL, with acceptance at cycle 0, produce rsp_valid first at cycle 4*DW+2+WAIT_CYCLES.
REQ-028 SHALL ignore req_valid and req_* changes while not in IDLE.
REQ-029 SHALL retain rsp_result/rsp_mult after handshake until the next CAPTURE completes.
REQ-030 SHALL use a single shared bit counter of width $clog2(2*DW)+1, cleared on every state entry.

Reset
REQ-031 SHALL, on reset, go to IDLE, clear counter and all data registers, and drive every output 0 except req_ready=1 the cycle after reset deasserts.
REQ-032 SHALL, on reset in any state, abort the transaction without asserting rsp_valid; reset wins over simultaneous handshakes.

Verification (DW=4, WAIT_CYCLES=2)
REQ-033 SHALL cover: req_a=4'hA accepted -> ser_a over 8 SHIFT cycles = 0,0,0,0,1,0,1,0; ser_red for req_red=8'h81 = 1,0,0,0,0,0,0,1.
REQ-034 SHALL cover: ser_out_mult and ser_out both driven 1,1,0,0,0,1,0,1 in CAPTURE -> rsp_mult=8'hC5, rsp_result=4'h5.
REQ-035 SHALL cover latency: accept at cycle 0 -> enable high only at cycle 9, rsp_valid first at cycle 20, req_ready low cycles 1..20.
REQ-036 SHALL cover backpressure: rsp_ready low 5 cycles -> rsp_valid and data held; handshake -> req_ready=1 next cycle; req_valid toggling mid-transaction has no effect.
REQ-037 SHALL cover reset asserted in CAPTURE -> next cycle IDLE, all outputs 0, no rsp_valid; new request then completes normally.
REQ-038 SHALL cover back-to-back requests with req_valid held high -> second accepted the cycle after first handshake's IDLE entry, function selects updated.

Source files
------------

// File: rtl/gf_serial_host.sv
// gf_serial_host: request/response front end for a bit-serial GF arithmetic
// core shell. Operands are shifted out MSB first, the core is pulsed, and the
// serial results are shifted back in and presented as a parallel response.
module gf_serial_host #(
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [DATA_WIDTH-1:0]         req_a,
  input  logic [DATA_WIDTH-1:0]         req_b,
  input  logic [$clog2(DATA_WIDTH):0]   req_grade,
  input  logic [DATA_WIDTH:0]           req_poly,
  input  logic [2*DATA_WIDTH-1:0]       req_red,
  input  logic                          req_sum_funct,
  input  logic                          req_exp_funct,
  input  logic                          req_red_funct,
  input  logic                          req_carry_option,
  output logic                          ser_a,
  output logic                          ser_b,
  output logic                          ser_grade,
  output logic                          ser_poly,
  output logic                          ser_red,
  output logic                          sum_funct,
  output logic                          exp_funct,
  output logic                          red_funct,
  output logic                          carry_option,
  output logic                          enable,
  input  logic                          ser_out,
  input  logic                          ser_out_mult,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic [2*DATA_WIDTH-1:0]       rsp_mult,
  output logic                          busy
);

  localparam int SW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(SW) + 1;
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    ENABLE  = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              accept;

  // Operands zero-extended to 2*DW so every line finishes on the same cycle.
  logic [SW-1:0]     sh_a;
  logic [SW-1:0]     sh_b;
  logic [SW-1:0]     sh_grade;
  logic [SW-1:0]     sh_poly;
  logic [SW-1:0]     sh_red;
  logic              fn_sum;
  logic              fn_exp;
  logic              fn_red;
  logic              fn_carry;

  logic [SW-1:0]         cap_mult;
  logic [DATA_WIDTH-1:0] cap_res;

  assign accept = (state == IDLE) && req_valid;

  // State register and shared bit counter, counter restarts on every state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = SHIFT;
      SHIFT:   if (bit_cnt == SW_LAST) state_next = ENABLE;
      ENABLE:  state_next = (WAIT_CYCLES == 0) ? CAPTURE : WAIT;
      WAIT:    if (bit_cnt == WAIT_LAST) state_next = CAPTURE;
      CAPTURE: if (bit_cnt == SW_LAST) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register the request on acceptance, then shift operands out MSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_grade <= '0;
      sh_poly  <= '0;
      sh_red   <= '0;
      fn_sum   <= 1'b0;
      fn_exp   <= 1'b0;
      fn_red   <= 1'b0;
      fn_carry <= 1'b0;
    end else if (accept) begin
      sh_a     <= SW'(req_a);
      sh_b     <= SW'(req_b);
      sh_grade <= SW'(req_grade);
      sh_poly  <= SW'(req_poly);
      sh_red   <= req_red;
      fn_sum   <= req_sum_funct;
      fn_exp   <= req_exp_funct;
      fn_red   <= req_red_funct;
      fn_carry <= req_carry_option;
    end else if (state == SHIFT) begin
      sh_a     <= sh_a << 1;
      sh_b     <= sh_b << 1;
      sh_grade <= sh_grade << 1;
      sh_poly  <= sh_poly << 1;
      sh_red   <= sh_red << 1;
    end
  end

  // Shift results in during CAPTURE; publish them only when the last bit lands
  // so the previous response stays visible until then.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_mult   <= '0;
      cap_res    <= '0;
      rsp_mult   <= '0;
      rsp_result <= '0;
    end else if (state == CAPTURE) begin
      cap_mult <= {cap_mult[SW-2:0], ser_out_mult};
      cap_res  <= {cap_res[DATA_WIDTH-2:0], ser_out};
      if (bit_cnt == SW_LAST) begin
        rsp_mult   <= {cap_mult[SW-2:0], ser_out_mult};
        rsp_result <= {cap_res[DATA_WIDTH-2:0], ser_out};
      end
    end
  end

  // State-decoded outputs.
  always_comb begin
    req_ready    = (state == IDLE);
    busy         = (state != IDLE);
    enable       = (state == ENABLE);
    rsp_valid    = (state == RESP);
    ser_a        = (state == SHIFT) && sh_a[SW-1];
    ser_b        = (state == SHIFT) && sh_b[SW-1];
    ser_grade    = (state == SHIFT) && sh_grade[SW-1];
    ser_poly     = (state == SHIFT) && sh_poly[SW-1];
    ser_red      = (state == SHIFT) && sh_red[SW-1];
    sum_funct    = (state != IDLE) && fn_sum;
    exp_funct    = (state != IDLE) && fn_exp;
    red_funct    = (state != IDLE) && fn_red;
    carry_option = (state != IDLE) && fn_carry;
  end

endmodule

// File: tb/tb_gf_serial_host.sv
// Testbench for gf_serial_host (DW=4, WAIT_CYCLES=2): randomized requests,
// expected responses queued at acceptance and popped by a response monitor.
module tb_gf_serial_host;

  localparam int DW        = 4;
  localparam int WC        = 2;
  localparam int SW        = 2 * DW;
  localparam int EN_CYC    = 2 * DW + 1;
  localparam int CAP_FIRST = 2 * DW + 2 + WC;
  localparam int RSP_CYC   = 4 * DW + 2 + WC;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [2:0]    req_grade;
  logic [DW:0]   req_poly;
  logic [SW-1:0] req_red;
  logic          req_sum_funct, req_exp_funct, req_red_funct, req_carry_option;
  logic          ser_a, ser_b, ser_grade, ser_poly, ser_red;
  logic          sum_funct, exp_funct, red_funct, carry_option, enable;
  logic          ser_out, ser_out_mult;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [SW-1:0] rsp_mult;
  logic          busy;

  always #5 clk = ~clk;

  gf_serial_host #(.DATA_WIDTH(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_grade(req_grade), .req_poly(req_poly),
    .req_red(req_red),
    .req_sum_funct(req_sum_funct), .req_exp_funct(req_exp_funct),
    .req_red_funct(req_red_funct), .req_carry_option(req_carry_option),
    .ser_a(ser_a), .ser_b(ser_b), .ser_grade(ser_grade), .ser_poly(ser_poly),
    .ser_red(ser_red),
    .sum_funct(sum_funct), .exp_funct(exp_funct), .red_funct(red_funct),
    .carry_option(carry_option), .enable(enable),
    .ser_out(ser_out), .ser_out_mult(ser_out_mult),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_mult(rsp_mult), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    grade;
    logic [DW:0]   poly;
    logic [SW-1:0] red;
    logic [3:0]    fn;
    logic [SW-1:0] m_bits;
    logic [SW-1:0] o_bits;
  } txn_t;

  typedef struct {
    logic [SW-1:0] mult;
    logic [DW-1:0] res;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [SW-1:0] last_mult = '0;
  logic [DW-1:0] last_res  = '0;
  bit            mon_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.a      = 4'($urandom);
    t.b      = 4'($urandom);
    t.grade  = 3'($urandom);
    t.poly   = 5'($urandom);
    t.red    = 8'($urandom);
    t.fn     = 4'($urandom);
    t.m_bits = 8'($urandom);
    t.o_bits = 8'($urandom);
    return t;
  endfunction

  task automatic drive_req(input txn_t t, input logic v);
    req_valid = v;
    req_a     = t.a;
    req_b     = t.b;
    req_grade = t.grade;
    req_poly  = t.poly;
    req_red   = t.red;
    {req_sum_funct, req_exp_funct, req_red_funct, req_carry_option} = t.fn;
  endtask

  // Response monitor: compares every presented response against the queue head
  // and checks that outputs hold their last value while no response is shown.
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_without_request", 64'(exp_q.size()), 64'd1);
        end else begin
          check("rsp_mult", 64'(rsp_mult), 64'(exp_q[0].mult));
          check("rsp_result", 64'(rsp_result), 64'(exp_q[0].res));
          if (rsp_ready) begin
            last_mult = exp_q[0].mult;
            last_res  = exp_q[0].res;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("rsp_mult_retained", 64'(rsp_mult), 64'(last_mult));
        check("rsp_result_retained", 64'(rsp_result), 64'(last_res));
      end
    end
  end

  // Runs one transaction from acceptance to the following IDLE cycle.
  // Entered right after a negedge; returns right after a negedge.
  task automatic run_txn(input txn_t t, input bit preapplied, input int hold,
                         input int rst_at, input bit chain, input txn_t nxt);
    int            waits;
    int            idx;
    exp_t          e;
    logic [SW-1:0] ea, eb, eg, ep, er;
    logic [4:0]    exp_ser;
    bit            aborted;
    aborted = 1'b0;
    if (!preapplied) begin
      @(posedge clk); #1;
      drive_req(t, 1'b1);
      @(negedge clk);
    end
    waits = 0;
    while (!(req_ready && req_valid) && waits < 60) begin
      @(posedge clk); #1;
      @(negedge clk);
      waits++;
    end
    check("accept_wait_cycles", 64'(waits), 64'd0);
    if (!(req_ready && req_valid)) return;

    e.mult = t.m_bits;
    e.res  = t.o_bits[DW-1:0];
    exp_q.push_back(e);
    ea = SW'(t.a);
    eb = SW'(t.b);
    eg = SW'(t.grade);
    ep = SW'(t.poly);
    er = t.red;

    for (int k = 1; k <= RSP_CYC + hold; k++) begin
      @(posedge clk); #1;
      if (chain) begin
        if (k == 1) drive_req(nxt, 1'b1);
      end else if (k < RSP_CYC - 1) begin
        drive_req(rand_txn(), 1'($urandom));
      end else begin
        req_valid = 1'b0;
      end
      if (k >= CAP_FIRST && k < CAP_FIRST + SW) begin
        ser_out_mult = t.m_bits[SW-1-(k-CAP_FIRST)];
        ser_out      = t.o_bits[SW-1-(k-CAP_FIRST)];
      end else begin
        ser_out_mult = 1'($urandom);
        ser_out      = 1'($urandom);
      end
      rsp_ready = (k == RSP_CYC + hold);
      if (k == rst_at) begin
        reset = 1'b1;
        void'(exp_q.pop_back());
        last_mult = '0;
        last_res  = '0;
      end
      @(negedge clk);
      if (k <= SW) begin
        idx = SW - k;
        exp_ser = {ea[idx], eb[idx], eg[idx], ep[idx], er[idx]};
      end else begin
        exp_ser = '0;
      end
      check("ser_lines", 64'({ser_a, ser_b, ser_grade, ser_poly, ser_red}), 64'(exp_ser));
      check("enable", 64'(enable), 64'(k == EN_CYC));
      check("req_ready_busy", 64'({req_ready, busy}), 64'b01);
      check("funct_selects", 64'({sum_funct, exp_funct, red_funct, carry_option}), 64'(t.fn));
      check("rsp_valid_timing", 64'(rsp_valid), 64'(k >= RSP_CYC));
      if (k == rst_at) begin
        aborted = 1'b1;
        break;
      end
    end

    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (aborted) begin
      reset     = 1'b0;
      req_valid = 1'b0;
    end
    @(negedge clk);
    check("idle_req_ready_busy", 64'({req_ready, busy}), 64'b10);
    check("idle_controls", 64'({enable, rsp_valid, sum_funct, exp_funct, red_funct,
                                carry_option, ser_a, ser_b, ser_grade, ser_poly, ser_red}), 64'd0);
    if (aborted)
      check("reset_clears_rsp", 64'({rsp_mult, rsp_result}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t t;
    txn_t n;
    bit   pre;
    bit   ch;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_a        = '0;
    req_b        = '0;
    req_grade    = '0;
    req_poly     = '0;
    req_red      = '0;
    {req_sum_funct, req_exp_funct, req_red_funct, req_carry_option} = 4'b0;
    ser_out      = 1'b0;
    ser_out_mult = 1'b0;
    rsp_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;
    check("reset_req_ready_busy", 64'({req_ready, busy}), 64'b10);
    check("reset_controls", 64'({enable, rsp_valid, sum_funct, exp_funct, red_funct,
                                 carry_option, ser_a, ser_b, ser_grade, ser_poly, ser_red}), 64'd0);
    check("reset_rsp_data", 64'({rsp_mult, rsp_result}), 64'd0);

    // Directed: A / 81 serial patterns and C5 capture stream.
    t = rand_txn();
    t.a      = 4'hA;
    t.red    = 8'h81;
    t.m_bits = 8'hC5;
    t.o_bits = 8'hC5;
    run_txn(t, 1'b0, 0, 0, 1'b0, t);

    // Backpressure: response held for 5 cycles.
    t = rand_txn();
    run_txn(t, 1'b0, 5, 0, 1'b0, t);

    // Reset during CAPTURE, then a normal transaction.
    t = rand_txn();
    run_txn(t, 1'b0, 0, CAP_FIRST + 2, 1'b0, t);
    t = rand_txn();
    run_txn(t, 1'b0, 1, 0, 1'b0, t);

    // Mix of back-to-back and isolated random transactions.
    pre = 1'b0;
    t   = rand_txn();
    for (int i = 0; i < 24; i++) begin
      ch = (i < 23) && ((i % 3) != 2);
      n  = rand_txn();
      run_txn(t, pre, int'($urandom_range(3, 0)), 0, ch, n);
      pre = ch;
      t   = ch ? n : rand_txn();
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
